lsu_pipe: RTL and testbench

Sequential load/store unit sitting between the EX stage and the data-memory port. It accepts one memory operation per transaction through a valid/ready handshake and drives a req/gnt/rvalid data-memory bus with byte enables. It returns sign- or zero-extended load results to writeback and reports misaligned, illegal-type and bus-timeout errors. Parametrised in data width, address width and timeout; at most one transaction is outstanding.

---
 rtl/lsu_pipe.sv | 194 +++++++++++++++++++
 tb/tb_lsu_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipe.sv
// Load/store unit: one outstanding memory operation between EX and a req/gnt/rvalid
// data-memory bus, with lane steering, load extension and error reporting.
module lsu_pipe #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              err_valid,
  output logic [1:0]        err_cause,
  output logic [ADDR_W-1:0] err_addr,
  output logic              busy
);

  localparam int NB    = XLEN / 8;
  localparam int OFF   = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [5:0] T_LB  = 6'd21;
  localparam logic [5:0] T_LH  = 6'd22;
  localparam logic [5:0] T_LW  = 6'd23;
  localparam logic [5:0] T_LBU = 6'd24;
  localparam logic [5:0] T_LHU = 6'd25;
  localparam logic [5:0] T_SB  = 6'd26;
  localparam logic [5:0] T_SH  = 6'd27;
  localparam logic [5:0] T_SW  = 6'd28;

  localparam logic [1:0] C_MISAL   = 2'b01;
  localparam logic [1:0] C_TIMEOUT = 2'b10;
  localparam logic [1:0] C_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              kill;
  logic [5:0]        type_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [4:0]        rd_p0;

  logic accept, type_ok, misal, acc_ok, acc_err;
  logic is_load_p0, to_hit, kill_now, rsp_p0;

  function automatic logic [NB-1:0] lane_be(input logic [5:0] t, input logic [OFF-1:0] off);
    logic [NB-1:0] base;
    case (t)
      T_LB, T_LBU, T_SB: base = NB'(1);
      T_LH, T_LHU, T_SH: base = NB'(3);
      default:           base = NB'(15);
    endcase
    return base << off;
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [5:0] t, input logic [XLEN-1:0] w);
    case (t)
      T_SB:    return {NB{w[7:0]}};
      T_SH:    return {(NB/2){w[15:0]}};
      default: return {(NB/4){w[31:0]}};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [5:0] t, input logic [OFF-1:0] off,
                                              input logic [XLEN-1:0] d);
    logic [XLEN-1:0]    s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    s = d >> {off, 3'b000};
    b = s[7:0];
    h = s[15:0];
    w = s[31:0];
    case (t)
      T_LB:    return XLEN'(b);
      T_LH:    return XLEN'(h);
      T_LW:    return XLEN'(w);
      T_LBU:   return XLEN'(s[7:0]);
      T_LHU:   return XLEN'(s[15:0]);
      default: return s;
    endcase
  endfunction

  assign accept     = req_valid && req_ready;
  assign type_ok    = (req_type >= T_LB) && (req_type <= T_SW);
  assign misal      = ((req_type == T_LH || req_type == T_LHU || req_type == T_SH) && req_addr[0]) ||
                      ((req_type == T_LW || req_type == T_SW) && (req_addr[1:0] != 2'b00));
  assign acc_ok     = accept && type_ok && !misal;
  assign acc_err    = accept && !(type_ok && !misal);
  assign is_load_p0 = (type_p0 <= T_LHU);
  assign rsp_p0     = (state == WAIT_R) && dmem_rvalid;
  assign kill_now   = kill || (flush && is_load_p0 && (state != IDLE));

  // A timeout loses to a handshake that lands in the same cycle.
  always_comb begin
    to_hit = 1'b0;
    if (TIMEOUT != 0 && cnt == CNT_LAST)
      to_hit = ((state == REQ) && !dmem_gnt) || ((state == WAIT_R) && !dmem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc_ok) state_nxt = REQ;
      REQ:     if (dmem_gnt) state_nxt = is_load_p0 ? WAIT_R : IDLE;
               else if (to_hit) state_nxt = IDLE;
      WAIT_R:  if (dmem_rvalid || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !flush && rst_n;
    busy      = (state != IDLE);
    dmem_req  = (state == REQ);
  end

  // Stage p0: request capture, bus drive and result/error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      kill       <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      err_valid  <= 1'b0;
      err_cause  <= '0;
      err_addr   <= '0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 1'b1;

      kill <= (state_nxt == IDLE) ? 1'b0 : kill_now;

      if (acc_ok) begin
        dmem_we    <= (req_type >= T_SB);
        dmem_addr  <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        dmem_be    <= lane_be(req_type, req_addr[OFF-1:0]);
        dmem_wdata <= lane_wdata(req_type, req_wdata);
      end

      wb_valid <= rsp_p0 && !kill_now;
      if (rsp_p0) begin
        wb_data <= load_ext(type_p0, addr_p0[OFF-1:0], dmem_rdata);
        wb_rd   <= rd_p0;
      end

      err_valid <= acc_err || (to_hit && !kill_now);
      if (acc_err) begin
        err_cause <= type_ok ? C_MISAL : C_ILLEGAL;
        err_addr  <= req_addr;
      end else if (to_hit) begin
        err_cause <= C_TIMEOUT;
        err_addr  <= addr_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_ok) begin
      type_p0 <= req_type;
      addr_p0 <= req_addr;
      rd_p0   <= req_rd;
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Bench for lsu_pipe: directed vector table, hand-written corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_lsu_pipe;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_ready;
  logic [5:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, err_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, err_addr;
  logic [1:0]  err_cause;

  int total = 0;
  int bad   = 0;

  lsu_pipe #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: access size, lane mask, replicated store data, extended load.
  function automatic int m_sz(input logic [5:0] t);
    if (t == 21 || t == 24 || t == 26) return 1;
    if (t == 22 || t == 25 || t == 27) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] m_cause(input logic [5:0] t, input logic [31:0] a);
    if (t < 21 || t > 28) return 2'd3;
    if (a % m_sz(t) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] t, input logic [31:0] a);
    int m;
    m = ((1 << m_sz(t)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] t, input logic [31:0] w);
    longint v, r;
    int sz;
    sz = m_sz(t);
    v = longint'(w) % (64'sd1 << (8 * sz));
    r = 0;
    for (int i = 0; i < 4 / sz; i++) r += v << (8 * sz * i);
    return 32'(r);
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
    longint lane, span;
    span = 64'sd1 << (8 * m_sz(t));
    lane = (longint'(d) >> (8 * (a % 4))) % span;
    if ((t == 21 || t == 22 || t == 23) && lane >= span / 2) lane -= span;
    return 32'(lane);
  endfunction

  // One transaction; bus timing and outcome follow from grant/rvalid delays and flush cycle.
  task automatic run_txn(input logic [5:0] t, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdv, input logic [4:0] rd, input int gdly,
                         input int rdly, input int flush_in, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] eres, input logic [1:0] ecause);
    bit is_load, to_req, to_w, killed, exp_wb, exp_err;
    int req_c, wait_c, pulse, fl;
    chk("ready_pre", req_ready, 1);
    req_valid = 1; req_type = t; req_addr = a; req_wdata = wd; req_rd = rd;
    step();
    req_valid = 0; req_type = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (ecause != 2'd0) begin
      chk("err_pulse", err_valid, 1);
      chk("err_cause", err_cause, ecause);
      chk("err_addr", err_addr, a);
      chk("err_noreq", dmem_req, 0);
      chk("err_ready", req_ready, 1);
      chk("err_nowb", wb_valid, 0);
      step();
      chk("err_single", err_valid, 0);
      return;
    end
    is_load = (t <= 25);
    to_req  = (gdly >= TO);
    req_c   = to_req ? TO : gdly + 1;
    to_w    = 0;
    wait_c  = 0;
    if (is_load && !to_req) begin
      to_w   = (rdly >= TO);
      wait_c = to_w ? TO : rdly + 1;
    end
    pulse   = 1 + req_c + wait_c;
    fl      = (flush_in > pulse - 2) ? 0 : flush_in;
    killed  = is_load && (fl != 0);
    exp_err = (to_req || to_w) && !killed;
    exp_wb  = is_load && !to_req && !to_w && !killed;
    for (int c = 1; c < pulse; c++) begin
      chk("busy", busy, 1);
      chk("dmem_req", dmem_req, 64'(c <= req_c));
      chk("early_wb", wb_valid, 0);
      chk("early_err", err_valid, 0);
      if (c <= req_c) begin
        chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk("dmem_be", dmem_be, ebe);
        chk("dmem_we", dmem_we, 64'(!is_load));
        if (!is_load) chk("dmem_wdata", dmem_wdata, ewd);
        dmem_gnt    = (c == gdly + 1);
        dmem_rvalid = 1'($urandom);
        dmem_rdata  = $urandom;
      end else begin
        dmem_gnt    = 0;
        dmem_rvalid = (c == req_c + 1 + rdly);
        dmem_rdata  = dmem_rvalid ? rdv : $urandom;
      end
      flush = (c == fl);
      step();
    end
    dmem_gnt = 0; dmem_rvalid = 0; flush = 0;
    chk("wb_valid", wb_valid, 64'(exp_wb));
    chk("err_valid", err_valid, 64'(exp_err));
    if (exp_wb) begin
      chk("wb_data", wb_data, eres);
      chk("wb_rd", wb_rd, rd);
    end
    if (exp_err) begin
      chk("to_cause", err_cause, 2'd2);
      chk("to_addr", err_addr, a);
    end
    chk("idle_busy", busy, 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_req", dmem_req, 0);
    step();
    chk("wb_single", wb_valid, 0);
    chk("err_single", err_valid, 0);
  endtask

  typedef struct {
    logic [5:0]  t;
    logic [31:0] a, wd, rdv;
    logic [3:0]  be;
    logic [31:0] ewd, eres;
    logic [1:0]  cause;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [5:0]  t;
    logic [31:0] a, wd, rdv;
    int          fl;

    vt[0]  = '{6'd21, 32'h1003, 32'h0, 32'h80FF_FF11, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'd0};
    vt[1]  = '{6'd24, 32'h1003, 32'h0, 32'h80FF_FF11, 4'b1000, 32'h0, 32'h0000_0080, 2'd0};
    vt[2]  = '{6'd22, 32'h1002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001, 2'd0};
    vt[3]  = '{6'd25, 32'h1002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'h0000_8001, 2'd0};
    vt[4]  = '{6'd23, 32'h1004, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2'd0};
    vt[5]  = '{6'd21, 32'h1000, 32'h0, 32'h1234_567F, 4'b0001, 32'h0, 32'h0000_007F, 2'd0};
    vt[6]  = '{6'd26, 32'h2001, 32'h1234_56AB, 32'h0, 4'b0010, 32'hABAB_ABAB, 32'h0, 2'd0};
    vt[7]  = '{6'd27, 32'h2002, 32'h1234_56AB, 32'h0, 4'b1100, 32'h56AB_56AB, 32'h0, 2'd0};
    vt[8]  = '{6'd28, 32'h2008, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 2'd0};
    vt[9]  = '{6'd23, 32'h3002, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'd1};
    vt[10] = '{6'd27, 32'h3001, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'd1};
    vt[11] = '{6'd22, 32'h3003, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'd1};
    vt[12] = '{6'd5,  32'h3000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'd3};
    vt[13] = '{6'd20, 32'h3000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'd3};
    vt[14] = '{6'd29, 32'h3001, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'd3};
    vt[15] = '{6'd25, 32'h1000, 32'h0, 32'hFFFF_ABCD, 4'b0011, 32'h0, 32'h0000_ABCD, 2'd0};

    rst_n = 0; flush = 0; req_valid = 0; req_type = 0; req_addr = 0; req_wdata = 0;
    req_rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    step();
    step();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
    chk("rst_err", {err_valid, err_cause, err_addr}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1;
    step();
    flush = 1;
    #1;
    chk("flush_ready", req_ready, 0);
    flush = 0;
    #1;

    foreach (vt[i])
      run_txn(vt[i].t, vt[i].a, vt[i].wd, vt[i].rdv, 5'(i + 1), 0, 0, 0,
              vt[i].be, vt[i].ewd, vt[i].eres, vt[i].cause);

    // Wait states: grant three cycles late, read data one cycle after the zero-wait slot.
    run_txn(6'd23, 32'h4000, 32'h0, 32'h0BAD_CAFE, 5'd7, 3, 1, 0,
            4'b1111, 32'h0, 32'h0BAD_CAFE, 2'd0);
    // Grant never arrives: timeout in REQ, for a store and a load.
    run_txn(6'd28, 32'h5004, 32'h1111_2222, 32'h0, 5'd3, 99, 0, 0,
            4'b1111, 32'h1111_2222, 32'h0, 2'd0);
    run_txn(6'd21, 32'h5005, 32'h0, 32'h0, 5'd4, 99, 0, 0,
            4'b0010, 32'h0, 32'h0, 2'd0);
    // Read data never arrives: timeout in WAIT_R.
    run_txn(6'd22, 32'h5006, 32'h0, 32'h0, 5'd5, 0, 99, 0,
            4'b1100, 32'h0, 32'h0, 2'd0);
    // Flush in WAIT_R of a word load: no writeback, still busy until rvalid.
    run_txn(6'd23, 32'h6000, 32'h0, 32'h1357_9BDF, 5'd9, 0, 3, 3,
            4'b1111, 32'h0, 32'h1357_9BDF, 2'd0);
    // Flush during a store is ignored.
    run_txn(6'd26, 32'h6003, 32'h0000_00C3, 32'h0, 5'd9, 1, 0, 1,
            4'b1000, 32'hC3C3_C3C3, 32'h0, 2'd0);

    // Reset while in REQ aborts with no pulses.
    req_valid = 1; req_type = 6'd23; req_addr = 32'h7000; req_rd = 5'd2;
    step();
    req_valid = 0;
    chk("mid_req", dmem_req, 1);
    rst_n = 0; dmem_gnt = 1;
    step();
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_pulse", {wb_valid, err_valid}, 0);
    rst_n = 1; dmem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_rvalid = 1; dmem_rdata = $urandom;
      step();
      chk("post_rst_pulse", {wb_valid, err_valid, busy}, 0);
    end
    dmem_rvalid = 0;

    for (int n = 0; n < 80; n++) begin
      t = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(21, 28));
      a = $urandom_range(0, 32'hFFFF);
      if ($urandom_range(0, 1) == 1) a = a & ~32'(m_sz(t) - 1);
      wd  = $urandom;
      rdv = $urandom;
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      run_txn(t, a, wd, rdv, 5'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), fl,
              m_be(t, a), m_wdata(t, wd), m_load(t, a, rdv), m_cause(t, a));
      if ($urandom_range(0, 3) == 0) begin
        dmem_rvalid = 1; dmem_gnt = 1; dmem_rdata = $urandom;
        step();
        dmem_rvalid = 0; dmem_gnt = 0;
        chk("idle_ignore", {wb_valid, err_valid, busy, dmem_req}, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
